gpio_input_unit: RTL

- Input-side companion of the GPIO output stage. It samples the external PA/PB pad levels and synchronises them into the clock domain as PINA/PINB.
- It also detects pin changes on bits enabled in PCMSK0/PCMSK1 and maintains the PCIFR flags.
- It raises the PCINT0/PCINT1 interrupt requests toward the interrupt controller.
- Pads carry the driven value whenever the DDR bit is set, so pins in output mode read back their own level here.

---
 rtl/gpio_input_unit.sv | 102 ++++++++++
 1 files changed

// File: rtl/gpio_input_unit.sv
// gpio_input_unit
//   Input side of the GPIO block. Brings the asynchronous PA/PB pad levels into
//   the clk domain through a two-stage synchroniser (PINA/PINB). It also flags
//   pin changes on mask-enabled bits in PCIFR and raises the PCINT0/PCINT1
//   requests.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-high reset
//   pa_pins        raw PA pad levels (async)
//   pb_pins        raw PB pad levels (async)
//   mem_pcmsk0     per-bit pin-change enable for PA
//   mem_pcmsk1     per-bit pin-change enable for PB
//   mem_pcicr      {PCIE1, PCIE0} interrupt request enables
//   pcifr_wr_en    CPU write strobe to PCIFR
//   pcifr_wr_data  write-one-to-clear data for PCIFR
//   irq_ack        vector-taken acknowledge, clears the matching flag
//   pina, pinb     synchronised pad levels
//   pcifr          pin-change flags {PCIF1, PCIF0}
//   pcint0_irq     PCINT0 request (registered)
//   pcint1_irq     PCINT1 request (registered)
module gpio_input_unit #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] pa_pins,
    input  logic [DATA_WIDTH-1:0] pb_pins,
    input  logic [DATA_WIDTH-1:0] mem_pcmsk0,
    input  logic [DATA_WIDTH-1:0] mem_pcmsk1,
    input  logic [1:0]            mem_pcicr,
    input  logic                  pcifr_wr_en,
    input  logic [1:0]            pcifr_wr_data,
    input  logic [1:0]            irq_ack,
    output logic [DATA_WIDTH-1:0] pina,
    output logic [DATA_WIDTH-1:0] pinb,
    output logic [1:0]            pcifr,
    output logic                  pcint0_irq,
    output logic                  pcint1_irq
);

    // Synchroniser stages and previous-sample registers.
    logic [DATA_WIDTH-1:0] pa_s1_q, pa_s2_q, pa_prev_q;
    logic [DATA_WIDTH-1:0] pb_s1_q, pb_s2_q, pb_prev_q;

    logic [1:0] warm_cnt_q, warm_cnt_d;
    logic       warm_done;

    logic [DATA_WIDTH-1:0] pa_chg, pb_chg;
    logic [1:0]            flag_set, flag_clr;
    logic [1:0]            pcifr_q, pcifr_d;
    logic [1:0]            irq_q, irq_d;

    always_comb begin
        // Detection stays off for the first three cycles after reset so that
        // pads already high at reset do not look like a 0->1 change.
        warm_done  = (warm_cnt_q == 2'd3);
        warm_cnt_d = warm_done ? warm_cnt_q : warm_cnt_q + 2'd1;

        // Mask is applied in the evaluation cycle; unmasked changes are lost.
        pa_chg = (pa_s2_q ^ pa_prev_q) & mem_pcmsk0;
        pb_chg = (pb_s2_q ^ pb_prev_q) & mem_pcmsk1;

        flag_set = {warm_done & (|pb_chg), warm_done & (|pa_chg)};
        flag_clr = ({2{pcifr_wr_en}} & pcifr_wr_data) | irq_ack;

        // Set wins over a simultaneous clear so no change is dropped.
        pcifr_d = (pcifr_q & ~flag_clr) | flag_set;
        irq_d   = pcifr_d & mem_pcicr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pa_s1_q    <= '0;
            pa_s2_q    <= '0;
            pa_prev_q  <= '0;
            pb_s1_q    <= '0;
            pb_s2_q    <= '0;
            pb_prev_q  <= '0;
            warm_cnt_q <= 2'd0;
            pcifr_q    <= 2'b00;
            irq_q      <= 2'b00;
        end else begin
            pa_s1_q    <= pa_pins;
            pa_s2_q    <= pa_s1_q;
            pa_prev_q  <= pa_s2_q;
            pb_s1_q    <= pb_pins;
            pb_s2_q    <= pb_s1_q;
            pb_prev_q  <= pb_s2_q;
            warm_cnt_q <= warm_cnt_d;
            pcifr_q    <= pcifr_d;
            irq_q      <= irq_d;
        end
    end

    assign pina       = pa_s2_q;
    assign pinb       = pb_s2_q;
    assign pcifr      = pcifr_q;
    assign pcint0_irq = irq_q[0];
    assign pcint1_irq = irq_q[1];

endmodule
